cfg_loader: RTL and testbench
=============================

CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 Parameter NUM_ADDRESSES, default 8, is the number of valid memory locations; a frame address is legal when it is < NUM_ADDRESSES.
REQ-002 Clocking SHALL be exactly: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 cfg_csn  input  1  serial chip-select, active-low, asynchronous to clk.
REQ-006 cfg_sclk  input  1  serial clock, asynchronous to clk, idle low.
REQ-007 cfg_sdi  input  1  serial data in, MSB first.
REQ-008 cfg_sdo  output  1  serial readback data, MSB first.
REQ-009 mem_addr  output  8  address to the memory block.
REQ-010 mem_wdata  output  8  write data to the memory block's data_in.
REQ-011 mem_wr_en  output  1  one-cycle write strobe.
REQ-012 mem_rd_en  output  1  one-cycle read strobe.
REQ-013 mem_rdata  input  8  memory data_out, valid one clk after mem_rd_en.
REQ-014 busy  output  1  high while a frame is in progress (cfg_csn low after sync).
REQ-015 frame_err  output  1  sticky error flag, cleared only by rst or by the start of the next frame.

Function
REQ-016 cfg_csn, cfg_sclk and cfg_sdi SHALL each pass through a 2-flop synchronizer; a third flop on sclk provides edge detection.
REQ-017 cfg_sdi SHALL be sampled on each detected sclk rising edge; cfg_sdo SHALL change only on detected sclk falling edges.
REQ-018 Frame = 16 bits: bit15 = R/nW (1 = read), bits14:8 = address (zero-extended to 8 bits on mem_addr), bits7:0 = write data (ignored for reads).
REQ-019 FSM states: IDLE, HDR, RD_REQ, RD_CAP, DATA, COMMIT, DRAIN.
REQ-020 IDLE -> HDR on synchronized csn falling; bit counter cleared, frame_err cleared.
REQ-021 HDR: after the 8th sampled bit, read -> RD_REQ; write -> DATA.
REQ-022 RD_REQ: mem_rd_en high exactly one cycle with mem_addr valid; -> RD_CAP.
REQ-023 RD_CAP: capture mem_rdata into the output shift register; drive its bit7 on cfg_sdo immediately; -> DATA.
REQ-024 DATA: shift in 8 bits (write) or shift out remaining bits on sclk falling edges (read); after the 16th sampled bit -> COMMIT (write) or DRAIN (read).
REQ-025 COMMIT: mem_wr_en high exactly one cycle with mem_addr/mem_wdata stable in that cycle; -> DRAIN.
REQ-026 DRAIN: ignore further sclk edges; -> IDLE on synchronized csn rising.
REQ-027 Illegal address (>= NUM_ADDRESSES): no mem_wr_en/mem_rd_en issued; read returns 8'h00 on cfg_sdo; frame_err set.
REQ-028 csn rising before 16 bits (any state but IDLE/DRAIN): abort to IDLE, no strobe issued, frame_err set.
REQ-029 mem_wr_en and mem_rd_en SHALL never be high in the same cycle.
REQ-030 Serial timing contract: sclk high and low phases each >= 4 clk periods; faster sclk is out of spec.

Reset
REQ-031 On rst: state IDLE, counters 0, mem_addr 0, mem_wdata 0, mem_wr_en 0, mem_rd_en 0, cfg_sdo 0, busy 0, frame_err 0, synchronizer flops set to idle levels (csn 1, sclk 0, sdi 0).
REQ-032 rst asserted mid-frame SHALL abort without any memory strobe; the remaining frame bits after rst are ignored until csn returns high.

Structure
REQ-033 Shared package holds the FSM state encoding, FRAME_BITS = 16, and the R/nW bit position.
REQ-034 One sub-module, cfg_sync2, implements the 2-flop synchronizer, instantiated three times.

Verification
REQ-035 Write frame 0x03A5 -> single mem_wr_en pulse with mem_addr 0x03, mem_wdata 0xA5; frame_err 0.
REQ-036 Memory preloaded 0x5C at addr 2, read frame 0x8200 -> one mem_rd_en with addr 0x02; cfg_sdo shifts out 0x5C MSB-first during bits 8-15.
REQ-037 Write frame 0x0911 with NUM_ADDRESSES = 8 -> no mem_wr_en; frame_err 1.
REQ-038 csn raised after 10 bits of frame 0x0122 -> no strobe, FSM in IDLE, frame_err 1; next valid frame clears frame_err.
REQ-039 rst pulsed after 12 bits of write frame 0x0477 -> all outputs at reset values, no mem_wr_en for the remainder of that frame.
REQ-040 Back-to-back writes 0x0011, 0x0122 with 8 clk csn-high gap -> two mem_wr_en pulses, addrs 0 then 1, data 0x11 then 0x22.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the serial configuration loader: frame geometry
// and the FSM state encoding.
package cfg_loader_pkg;

  localparam int FRAME_BITS = 16;
  localparam int HDR_BITS   = 8;
  // Frame bit carrying R/nW (1 = read); it is the first bit on the wire.
  localparam int RNW_BIT    = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_RD_REQ = 3'd2,
    ST_RD_CAP = 3'd3,
    ST_DATA   = 3'd4,
    ST_COMMIT = 3'd5,
    ST_DRAIN  = 3'd6
  } state_t;

endpackage

// File: rtl/cfg_sync2.sv
// Two-flop synchronizer for one asynchronous input; reset value selects the
// idle level so a reset never manufactures an edge on the synchronized side.
module cfg_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// Serial (SPI-like, mode 0) configuration loader. A 16-bit frame carries
// R/nW, a 7-bit address and 8 bits of write data; writes become a single
// memory write strobe, reads fetch one byte and shift it back on cfg_sdo.
//
// Handshake: mem_wr_en / mem_rd_en are single-cycle strobes, never both high;
// mem_addr (and mem_wdata for writes) is stable in the strobe cycle, and
// mem_rdata is taken exactly one clk after mem_rd_en.
module cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int NUM_ADDRESSES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_csn,
  input  logic       cfg_sclk,
  input  logic       cfg_sdi,
  output logic       cfg_sdo,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_wr_en,
  output logic       mem_rd_en,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       frame_err,
  output logic [2:0] dbg_state
);

  localparam logic [4:0] HDR_LAST    = 5'(HDR_BITS - 1);
  localparam logic [4:0] FRAME_LAST  = 5'(FRAME_BITS - 1);
  // Readback shifts only after the first data-phase sample, so the falling
  // edge that closes the header never skips bit 7.
  localparam logic [4:0] SHIFT_FIRST = 5'(HDR_BITS + 1);
  localparam int         HDR_RNW     = RNW_BIT - HDR_BITS;
  localparam logic [8:0] ADDR_LIMIT  = 9'(NUM_ADDRESSES);

  state_t     state, next_state;
  logic       csn_s, sclk_s, sdi_s, sclk_d;
  logic       sclk_rise, sclk_fall;
  logic [1:0] settle;
  logic       armed;
  logic [4:0] bit_cnt;
  logic [6:0] shift_in;
  logic [6:0] out_sr;
  logic       rnw, addr_ok;
  logic [7:0] hdr, hdr_addr, rd_byte;
  logic       addr_legal;

  cfg_sync2 #(.RESET_VAL(1'b1)) u_sync_csn  (.clk(clk), .rst(rst), .d(cfg_csn),  .q(csn_s));
  cfg_sync2 #(.RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(cfg_sclk), .q(sclk_s));
  cfg_sync2 #(.RESET_VAL(1'b0)) u_sync_sdi  (.clk(clk), .rst(rst), .d(cfg_sdi),  .q(sdi_s));

  assign sclk_rise  = sclk_s & ~sclk_d;
  assign sclk_fall  = ~sclk_s & sclk_d;
  assign hdr        = {shift_in, sdi_s};
  assign hdr_addr   = {1'b0, hdr[6:0]};
  assign addr_legal = {1'b0, hdr_addr} < ADDR_LIMIT;
  assign rd_byte    = addr_ok ? mem_rdata : 8'h00;
  assign dbg_state  = state;

  // Third sclk flop for edge detection; settle/armed gate frame start until
  // the synchronizers have flushed and csn has been seen high, so a reset
  // in the middle of a frame ignores the rest of that frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d <= 1'b0;
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && csn_s) armed <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; csn rising in HDR/DATA aborts the frame.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (armed && !csn_s) next_state = ST_HDR;
      ST_HDR: begin
        if (csn_s) next_state = ST_IDLE;
        else if (sclk_rise && bit_cnt == HDR_LAST)
          next_state = hdr[HDR_RNW] ? ST_RD_REQ : ST_DATA;
      end
      ST_RD_REQ: next_state = ST_RD_CAP;
      ST_RD_CAP: next_state = ST_DATA;
      ST_DATA: begin
        if (csn_s) next_state = ST_IDLE;
        else if (sclk_rise && bit_cnt == FRAME_LAST)
          next_state = rnw ? ST_DRAIN : ST_COMMIT;
      end
      ST_COMMIT: next_state = ST_DRAIN;
      ST_DRAIN:  if (csn_s) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Moore outputs; illegal addresses suppress the strobes.
  always_comb begin
    mem_rd_en = (state == ST_RD_REQ) && addr_ok;
    mem_wr_en = (state == ST_COMMIT) && addr_ok;
    busy      = (state != ST_IDLE);
  end

  // Frame datapath: bit counting, header decode, write data, readback shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_in  <= '0;
      out_sr    <= '0;
      cfg_sdo   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rnw       <= 1'b0;
      addr_ok   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          if (next_state == ST_HDR) frame_err <= 1'b0;
        end
        ST_HDR: begin
          if (csn_s) frame_err <= 1'b1;
          else if (sclk_rise) begin
            shift_in <= hdr[6:0];
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == HDR_LAST) begin
              rnw      <= hdr[HDR_RNW];
              mem_addr <= hdr_addr;
              addr_ok  <= addr_legal;
              if (!addr_legal) frame_err <= 1'b1;
            end
          end
        end
        ST_RD_CAP: begin
          out_sr  <= rd_byte[6:0];
          cfg_sdo <= rd_byte[7];
        end
        ST_DATA: begin
          if (csn_s) frame_err <= 1'b1;
          else begin
            if (sclk_rise) begin
              shift_in <= hdr[6:0];
              bit_cnt  <= bit_cnt + 5'd1;
              if (!rnw && bit_cnt == FRAME_LAST) mem_wdata <= hdr;
            end
            if (rnw && sclk_fall && bit_cnt >= SHIFT_FIRST) begin
              out_sr  <= {out_sr[5:0], 1'b0};
              cfg_sdo <= out_sr[6];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Bench for cfg_loader: mode-0 serial master, a one-cycle-latency memory
// model, and a strobe scoreboard fed by the frames the master sends.
module tb_cfg_loader;

  localparam int HALF = 6;   // sclk phase length in clk periods

  logic       clk, rst;
  logic       cfg_csn, cfg_sclk, cfg_sdi, cfg_sdo;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_wr_en, mem_rd_en, busy, frame_err;
  logic [2:0] dbg_state;

  logic       pl_en;
  logic [7:0] pl_addr, pl_data;
  logic [7:0] mem [0:255];
  logic [7:0] ref_mem [0:7];

  logic [16:0] exp_q[$];   // {is_read, addr, wdata or 0}
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] rd_data;

  cfg_loader #(.NUM_ADDRESSES(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_csn(cfg_csn), .cfg_sclk(cfg_sclk), .cfg_sdi(cfg_sdi), .cfg_sdo(cfg_sdo),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .busy(busy), .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: preload port, write on strobe, read data one clk later.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Scoreboard: every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (mem_wr_en || mem_rd_en) begin
      check("strobe_mutex", 32'(mem_wr_en & mem_rd_en), 32'd0);
      check("strobe_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("strobe", 32'({mem_rd_en, mem_addr, mem_rd_en ? 8'h00 : mem_wdata}),
              32'(exp_q.pop_front()));
    end
  end

  // Driver tasks
  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] f, input int first, input int last,
                           output logic [7:0] rd);
    rd = '0;
    for (int i = first; i <= last; i++) begin
      cfg_sdi = f[15-i];
      repeat (HALF) @(negedge clk);
      if (i >= 8) rd[15-i] = cfg_sdo;
      cfg_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      cfg_sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [15:0] f, input int gap, output logic [7:0] rd);
    cfg_csn = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(f, 0, 15, rd);
    repeat (HALF) @(negedge clk);
    cfg_csn = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic write_frame(input logic [6:0] a, input logic [7:0] d, input int gap);
    logic [7:0] unused_rd;
    if (a < 7'd8) begin
      exp_q.push_back({1'b0, 1'b0, a, d});
      ref_mem[a[2:0]] = d;
    end
    run_frame({1'b0, a, d}, gap, unused_rd);
  endtask

  task automatic read_frame(input logic [6:0] a, output logic [7:0] rd);
    if (a < 7'd8) exp_q.push_back({1'b1, 1'b0, a, 8'h00});
    run_frame({1'b1, a, 8'h00}, 12, rd);
  endtask

  task automatic end_checks(input string tag, input logic err_exp);
    check({tag, "_err"}, 32'(frame_err), 32'(err_exp));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_wr"}, 32'(mem_wr_en), 32'd0);
    check({tag, "_rd"}, 32'(mem_rd_en), 32'd0);
    check({tag, "_sdo"}, 32'(cfg_sdo), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_csn = 1'b1; cfg_sclk = 1'b0; cfg_sdi = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = (i == 2) ? 8'h5C : 8'(i * 17 + 3);
      preload(8'(i), ref_mem[i]);
    end
    rst = 1'b0;
    @(negedge clk);
    reset_checks("reset");
    repeat (10) @(negedge clk);

    // Plain write
    write_frame(7'h03, 8'hA5, 12);
    end_checks("wr_03a5", 1'b0);

    // Read of preloaded location
    read_frame(7'h02, rd_data);
    check("rd_02_data", 32'(rd_data), 32'h5C);
    end_checks("rd_02", 1'b0);

    // Illegal write and read
    write_frame(7'h09, 8'h11, 12);
    end_checks("wr_illegal", 1'b1);
    read_frame(7'h0A, rd_data);
    check("rd_illegal_data", 32'(rd_data), 32'h00);
    end_checks("rd_illegal", 1'b1);

    // Abort after 10 bits, then a valid frame clears the error
    cfg_csn = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(16'h0122, 0, 9, rd_data);
    repeat (HALF) @(negedge clk);
    cfg_csn = 1'b1;
    repeat (8) @(negedge clk);
    end_checks("abort", 1'b1);
    exp_q.push_back({1'b0, 8'h01, 8'h55});
    ref_mem[1] = 8'h55;
    cfg_csn = 1'b0;
    repeat (HALF) @(negedge clk);
    check("err_clr_start", 32'(frame_err), 32'd0);
    check("busy_in_frame", 32'(busy), 32'd1);
    send_bits(16'h0155, 0, 15, rd_data);
    repeat (HALF) @(negedge clk);
    cfg_csn = 1'b1;
    repeat (12) @(negedge clk);
    end_checks("after_abort", 1'b0);

    // Reset after 12 bits of a write; the remainder must be ignored
    cfg_csn = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(16'h0477, 0, 11, rd_data);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    reset_checks("mid_rst");
    send_bits(16'h0477, 12, 15, rd_data);
    repeat (HALF) @(negedge clk);
    check("mid_rst_ignored", 32'(dbg_state), 32'd0);
    cfg_csn = 1'b1;
    repeat (12) @(negedge clk);
    end_checks("mid_rst", 1'b0);

    // Back-to-back writes with an 8-clk gap
    write_frame(7'h00, 8'h11, 8);
    write_frame(7'h01, 8'h22, 12);
    end_checks("b2b", 1'b0);

    // Random legal writes, then read every location back
    for (int k = 0; k < 4; k++)
      write_frame(7'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 10);
    for (int a = 0; a < 8; a++) begin
      read_frame(7'(a), rd_data);
      check($sformatf("rdback_%0d", a), 32'(rd_data), 32'(ref_mem[a]));
    end
    end_checks("final", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
